anotherworld_thread_scheduler: RTL and testbench



---
 rtl/anotherworld_thread_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_anotherworld_thread_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anotherworld_thread_scheduler.sv
// Per-frame cooperative thread scheduler for the Another World VM core.
// Commits pending setVec/freeze/unfreeze/kill requests at frame start, then
// dispatches runnable threads to the CPU in ascending order via run/done.
module anotherworld_thread_scheduler #(
    parameter int unsigned NUM_THREADS = 64,
    parameter int unsigned PCW         = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           frame_start,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_op,
    input  logic [5:0]     req_first,
    input  logic [5:0]     req_last,
    input  logic [PCW-1:0] req_pc,
    output logic           run_valid,
    input  logic           run_ready,
    output logic [5:0]     run_thread,
    output logic [PCW-1:0] run_pc,
    input  logic           done_valid,
    input  logic           done_kill,
    input  logic [PCW-1:0] done_pc,
    output logic           busy,
    output logic           frame_done
);

    localparam int unsigned    IW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam logic [IW-1:0]  LAST_IDX    = IW'(NUM_THREADS - 1);
    localparam logic [PCW-1:0] PC_INACTIVE = {PCW{1'b1}};
    localparam logic [PCW-1:0] PC_KILL     = PC_INACTIVE - PCW'(1);
    localparam logic [1:0]     OP_SETVEC   = 2'd0;
    localparam logic [1:0]     OP_FREEZE   = 2'd1;
    localparam logic [1:0]     OP_UNFREEZE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SCAN, S_ISSUE, S_EXEC, S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   frame_pend_q, frame_pend_d;
    logic [PCW-1:0]         pc_q [NUM_THREADS];
    logic [PCW-1:0]         pc_d [NUM_THREADS];
    logic [PCW-1:0]         pend_pc_q [NUM_THREADS];
    logic [PCW-1:0]         pend_pc_d [NUM_THREADS];
    logic [1:0]             pend_pause_q [NUM_THREADS];
    logic [1:0]             pend_pause_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] paused_q, paused_d;
    logic                   rng_act_q, rng_act_d;
    logic [5:0]             rng_idx_q, rng_idx_d;
    logic [5:0]             rng_last_q, rng_last_d;
    logic [1:0]             rng_op_q, rng_op_d;
    logic                   req_ready_q, req_ready_d;
    logic                   run_valid_q, run_valid_d;
    logic [5:0]             run_thread_q, run_thread_d;
    logic [PCW-1:0]         run_pc_q, run_pc_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   req_acc;

    assign req_ready  = req_ready_q;
    assign run_valid  = run_valid_q;
    assign run_thread = run_thread_q;
    assign run_pc     = run_pc_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    // Request engine, frame FSM and per-thread storage next-state
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_pend_d = frame_pend_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_pause_d = pend_pause_q;
        paused_d     = paused_q;
        rng_act_d    = rng_act_q;
        rng_idx_d    = rng_idx_q;
        rng_last_d   = rng_last_q;
        rng_op_d     = rng_op_q;
        run_thread_d = run_thread_q;
        run_pc_d     = run_pc_q;
        req_acc      = req_valid && req_ready_q;

        // setVec lands immediately; range ops walk one slot per cycle
        if (req_acc) begin
            if (req_op == OP_SETVEC) begin
                pend_pc_d[IW'(req_first)] = req_pc;
            end else if (req_first <= req_last) begin
                rng_act_d  = 1'b1;
                rng_idx_d  = req_first;
                rng_last_d = req_last;
                rng_op_d   = req_op;
            end
        end else if (rng_act_q) begin
            case (rng_op_q)
                OP_FREEZE:   pend_pause_d[IW'(rng_idx_q)] = 2'd1;
                OP_UNFREEZE: pend_pause_d[IW'(rng_idx_q)] = 2'd2;
                default:     pend_pc_d[IW'(rng_idx_q)]    = PC_KILL;
            endcase
            if (rng_idx_q == rng_last_q) begin
                rng_act_d = 1'b0;
            end else begin
                rng_idx_d = rng_idx_q + 6'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // A range op still walking holds off APPLY until it finishes
                if (frame_start || frame_pend_q) begin
                    if (rng_act_d) begin
                        frame_pend_d = 1'b1;
                    end else begin
                        frame_pend_d = 1'b0;
                        state_d      = S_APPLY;
                        idx_d        = '0;
                    end
                end
            end
            S_APPLY: begin
                if (pend_pc_q[idx_q] == PC_KILL) begin
                    pc_d[idx_q] = PC_INACTIVE;
                end else if (pend_pc_q[idx_q] != PC_INACTIVE) begin
                    pc_d[idx_q] = pend_pc_q[idx_q];
                end
                if (pend_pause_q[idx_q] != 2'd0) begin
                    paused_d[idx_q] = (pend_pause_q[idx_q] == 2'd1);
                end
                pend_pc_d[idx_q]    = PC_INACTIVE;
                pend_pause_d[idx_q] = 2'd0;
                if (idx_q == LAST_IDX) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SCAN: begin
                if (pc_q[idx_q] != PC_INACTIVE && !paused_q[idx_q]) begin
                    state_d      = S_ISSUE;
                    run_thread_d = 6'(idx_q);
                    run_pc_d     = pc_q[idx_q];
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_ISSUE: begin
                if (run_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done_valid) begin
                    pc_d[idx_q] = done_kill ? PC_INACTIVE : done_pc;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        run_valid_d  = (state_d == S_ISSUE);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
        req_ready_d  = !(req_acc && req_op != OP_SETVEC) && !rng_act_d &&
                       !frame_pend_d && (state_d != S_APPLY);
    end

    // State, storage and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            frame_pend_q <= 1'b0;
            for (int k = 0; k < int'(NUM_THREADS); k++) begin
                pc_q[k]         <= (k == 0) ? '0 : PC_INACTIVE;
                pend_pc_q[k]    <= PC_INACTIVE;
                pend_pause_q[k] <= 2'd0;
            end
            paused_q     <= '0;
            rng_act_q    <= 1'b0;
            rng_idx_q    <= '0;
            rng_last_q   <= '0;
            rng_op_q     <= '0;
            req_ready_q  <= 1'b1;
            run_valid_q  <= 1'b0;
            run_thread_q <= '0;
            run_pc_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_pend_q <= frame_pend_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_pause_q <= pend_pause_d;
            paused_q     <= paused_d;
            rng_act_q    <= rng_act_d;
            rng_idx_q    <= rng_idx_d;
            rng_last_q   <= rng_last_d;
            rng_op_q     <= rng_op_d;
            req_ready_q  <= req_ready_d;
            run_valid_q  <= run_valid_d;
            run_thread_q <= run_thread_d;
            run_pc_q     <= run_pc_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_anotherworld_thread_scheduler.sv
// Directed bench for anotherworld_thread_scheduler: frame timing, dispatch
// order/PCs, request effects, handshake stall and mid-frame reset.
module tb_anotherworld_thread_scheduler;

    localparam int unsigned NT  = 64;
    localparam int unsigned PCW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           frame_start;
    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [5:0]     req_first;
    logic [5:0]     req_last;
    logic [PCW-1:0] req_pc;
    logic           run_valid;
    logic           run_ready;
    logic [5:0]     run_thread;
    logic [PCW-1:0] run_pc;
    logic           done_valid;
    logic           done_kill;
    logic [PCW-1:0] done_pc;
    logic           busy;
    logic           frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PCW-1:0] dpc [NT];
    logic           dkill [NT];
    int disp_t[$];
    int disp_pc[$];
    int exp_t[$];
    int exp_pc[$];
    int frame_len;

    anotherworld_thread_scheduler #(.NUM_THREADS(NT), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_first(req_first), .req_last(req_last), .req_pc(req_pc),
        .run_valid(run_valid), .run_ready(run_ready), .run_thread(run_thread),
        .run_pc(run_pc), .done_valid(done_valid), .done_kill(done_kill),
        .done_pc(done_pc), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_exp(input int t, input int pc);
        exp_t.push_back(t);
        exp_pc.push_back(pc);
    endtask

    // Compare recorded dispatches against the expected list, then clear it
    task automatic check_disp(input string tag);
        int n;
        chk($sformatf("%s_count", tag), 32'(disp_t.size()), 32'(exp_t.size()));
        n = (disp_t.size() < exp_t.size()) ? disp_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_thread%0d", tag, i), 32'(disp_t[i]), 32'(exp_t[i]));
            chk($sformatf("%s_pc%0d", tag, i), 32'(disp_pc[i]), 32'(exp_pc[i]));
        end
        exp_t.delete();
        exp_pc.delete();
    endtask

    // One frame with zero-wait CPU; optional setVec injected during a thread's EXEC
    task automatic run_frame(input int inj_thread, input logic [PCW-1:0] inj_pc);
        int inj_st;
        int cyc;
        bit got;
        disp_t.delete();
        disp_pc.delete();
        frame_len = -1;
        inj_st = 0;
        got = 1'b0;
        frame_start = 1'b1;
        run_ready = 1'b1;
        done_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        cyc = 1;
        while (!got && cyc < 3000) begin
            if (inj_st == 2) begin
                req_valid = 1'b0;
                inj_st = 3;
            end
            if (inj_st == 1) begin
                chk("inj_req_ready", 32'(req_ready), 32'd1);
                req_valid = 1'b1;
                req_op = 2'd0;
                req_first = 6'(inj_thread);
                req_pc = inj_pc;
                inj_st = 2;
            end
            if (run_valid) begin
                disp_t.push_back(int'(run_thread));
                disp_pc.push_back(int'(run_pc));
                done_pc = dpc[run_thread];
                done_kill = dkill[run_thread];
                if (int'(run_thread) == inj_thread && inj_st == 0) inj_st = 1;
            end
            if (frame_done) begin
                got = 1'b1;
                frame_len = cyc;
            end
            if (!got) begin
                tick();
                cyc++;
            end
        end
        done_valid = 1'b0;
        req_valid = 1'b0;
        chk("frame_done_seen", 32'(got), 32'd1);
        tick();
        chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
        chk("idle_after_frame", 32'(busy), 32'd0);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [5:0] f, input logic [5:0] l,
                          input logic [PCW-1:0] pc, output int low);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_op = op;
        req_first = f;
        req_last = l;
        req_pc = pc;
        while (!req_ready && w < 100) begin
            tick();
            w++;
        end
        tick();
        req_valid = 1'b0;
        low = 0;
        while (!req_ready && low < 100) begin
            tick();
            low++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_run_valid"}, 32'(run_valid), 32'd0);
        chk({tag, "_run_thread"}, 32'(run_thread), 32'd0);
        chk({tag, "_run_pc"}, 32'(run_pc), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int low;
        int cyc;
        reset = 1'b0;
        frame_start = 1'b0;
        req_valid = 1'b0;
        req_op = 2'd0;
        req_first = 6'd0;
        req_last = 6'd0;
        req_pc = '0;
        run_ready = 1'b0;
        done_valid = 1'b0;
        done_kill = 1'b0;
        done_pc = '0;
        for (int t = 0; t < int'(NT); t++) begin
            dpc[t] = '0;
            dkill[t] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        chk_reset_outputs("boot");

        // Boot frame: only thread 0 at pc 0
        dpc[0] = 16'h0042;
        run_frame(-1, '0);
        add_exp(0, 'h0000);
        check_disp("f1");
        chk("f1_len", 32'(frame_len), 32'd131);

        run_frame(-1, '0);
        add_exp(0, 'h0042);
        check_disp("f2");
        chk("f2_len", 32'(frame_len), 32'd131);

        // setVec in IDLE
        do_req(2'd0, 6'd5, 6'd0, 16'h1234, low);
        chk("setvec_ready_low", 32'(low), 32'd0);
        dpc[5] = 16'h1234;
        run_frame(-1, '0);
        add_exp(0, 'h0042);
        add_exp(5, 'h1234);
        check_disp("f3");
        chk("f3_len", 32'(frame_len), 32'd133);

        // setVec during thread 0 EXEC only lands at the next APPLY
        dpc[0] = 16'h0080;
        run_frame(0, 16'h0100);
        add_exp(0, 'h0042);
        add_exp(5, 'h1234);
        check_disp("f4");
        dpc[0] = 16'h0100;
        run_frame(-1, '0);
        add_exp(0, 'h0100);
        add_exp(5, 'h1234);
        check_disp("f5");

        // Activate 1..9, freeze 2..7
        for (int t = 1; t <= 9; t++) begin
            do_req(2'd0, 6'(t), 6'(t), 16'(32'h200 + t), low);
            dpc[t] = 16'(32'h200 + t);
        end
        do_req(2'd1, 6'd2, 6'd7, '0, low);
        chk("freeze_ready_low", 32'(low), 32'd6);
        run_frame(-1, '0);
        add_exp(0, 'h0100);
        add_exp(1, 'h0201);
        add_exp(8, 'h0208);
        add_exp(9, 'h0209);
        check_disp("f6");
        chk("f6_len", 32'(frame_len), 32'd137);

        // Unfreeze; thread 3 kills itself this frame
        do_req(2'd2, 6'd2, 6'd7, '0, low);
        chk("unfreeze_ready_low", 32'(low), 32'd6);
        dkill[3] = 1'b1;
        run_frame(-1, '0);
        add_exp(0, 'h0100);
        for (int t = 1; t <= 9; t++) add_exp(t, 'h200 + t);
        check_disp("f7");
        chk("f7_len", 32'(frame_len), 32'd149);
        dkill[3] = 1'b0;

        // Kill range 4..4 and an empty range
        do_req(2'd3, 6'd4, 6'd4, '0, low);
        chk("kill_ready_low", 32'(low), 32'd1);
        do_req(2'd3, 6'd9, 6'd2, '0, low);
        chk("noop_ready_low", 32'(low), 32'd1);
        run_frame(-1, '0);
        add_exp(0, 'h0100);
        add_exp(1, 'h0201);
        add_exp(2, 'h0202);
        for (int t = 5; t <= 9; t++) add_exp(t, 'h200 + t);
        check_disp("f8");
        chk("f8_len", 32'(frame_len), 32'd145);

        // Stalled dispatch, then reset during EXEC
        frame_start = 1'b1;
        run_ready = 1'b0;
        done_valid = 1'b0;
        tick();
        frame_start = 1'b0;
        chk("apply_req_ready", 32'(req_ready), 32'd0);
        cyc = 1;
        while (!run_valid && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("stall_issue_cycle", 32'(cyc), 32'd66);
        chk("stall_thread", 32'(run_thread), 32'd0);
        chk("stall_pc", 32'(run_pc), 32'h0100);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("stall%0d_valid", k), 32'(run_valid), 32'd1);
            chk($sformatf("stall%0d_thread", k), 32'(run_thread), 32'd0);
            chk($sformatf("stall%0d_pc", k), 32'(run_pc), 32'h0100);
        end
        run_ready = 1'b1;
        tick();
        run_ready = 1'b0;
        chk("exec_run_valid", 32'(run_valid), 32'd0);
        chk("exec_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        reset = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        dpc[0] = 16'h0000;
        run_frame(-1, '0);
        add_exp(0, 'h0000);
        check_disp("f9");
        chk("f9_len", 32'(frame_len), 32'd131);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
